// File: rtl/stack_port_unit.sv
// Stack request responder: push 2 cycles, pop/peek response 2 cycles after acceptance, clear/errored push 1 cycle.
// Backpressure: cmd_ready is high only in IDLE outside reset; requests offered while low are dropped.
module stack_port_unit #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE   = 16'h27FF,
    parameter int                DEPTH  = 256,
    localparam int               CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] sp,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_udf;
    logic [DATA_W-1:0]   r_data;
    logic                r_pop;
    logic                r_und;
    logic [DATA_W-1:0]   r_rsp_hold;

    logic                w_accept;
    logic                w_empty;
    logic                w_full;
    logic [ADDR_W-1:0]   w_sp;
    logic [DATA_W-1:0]   w_rsp_val;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_sp      = BASE - ADDR_W'(r_count);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_rsp_val = r_und ? '0 : mem_rdata;

    assign sp    = w_sp;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are masked by rst so a request caught by reset never reaches memory.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_data  = r_rsp_hold;
        case (r_state)
            S_IDLE: begin
                cmd_ready = !rst;
                if (w_accept) begin
                    case (cmd_op)
                        OP_PUSH:  w_next = w_full ? S_IDLE : S_WRITE;
                        OP_CLEAR: w_next = S_IDLE;
                        default:  w_next = w_empty ? S_RESP : S_READ;
                    endcase
                end
            end
            S_WRITE: begin
                mem_we    = !rst;
                mem_addr  = w_sp;
                mem_wdata = r_data;
                w_next    = S_IDLE;
            end
            S_READ: begin
                mem_re   = !rst;
                mem_addr = w_sp + ADDR_W'(1);
                w_next   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = !rst;
                rsp_data  = rst ? r_rsp_hold : w_rsp_val;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_data     <= '0;
            r_pop      <= 1'b0;
            r_und      <= 1'b0;
            r_rsp_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= cmd_data;
                        r_pop  <= (cmd_op == OP_POP);
                        r_und  <= 1'b0;
                        case (cmd_op)
                            OP_PUSH: begin
                                if (w_full) r_ovf <= 1'b1;
                            end
                            OP_CLEAR: begin
                                r_count <= '0;
                                r_ovf   <= 1'b0;
                                r_udf   <= 1'b0;
                            end
                            default: begin
                                if (w_empty) begin
                                    r_und <= 1'b1;
                                    r_udf <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_WRITE: r_count <= r_count + CNT_W'(1);
                S_RESP: begin
                    r_rsp_hold <= w_rsp_val;
                    if (r_pop && !r_und) r_count <= r_count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_port_unit.sv
// Randomized bench for stack_port_unit (DEPTH=4) against a queue-based stack model and a behavioural memory.
module tb_stack_port_unit;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h27FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] sp;
    logic [2:0]  count;
    logic        empty, full, ovf, udf;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int re_cnt = 0;

    logic [15:0] tb_mem [0:65535];
    logic [15:0] m_q[$];
    logic        m_ovf, m_udf;

    stack_port_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sp(sp), .count(count), .empty(empty), .full(full), .ovf(ovf), .udf(udf),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= tb_mem[mem_addr];
            re_cnt <= re_cnt + 1;
        end else begin
            mem_rdata <= 16'hDEAD;
        end
    end

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic check_visible(input string tag);
        logic [15:0] exp_sp;
        exp_sp = BASE - 16'(m_q.size());
        total++; if (count !== 3'(m_q.size())) begin bad++; $display("FAIL %s count got=%0d want=%0d", tag, count, m_q.size()); end
        total++; if (sp !== exp_sp) begin bad++; $display("FAIL %s sp got=%h want=%h", tag, sp, exp_sp); end
        total++; if (empty !== (m_q.size() == 0)) begin bad++; $display("FAIL %s empty got=%b", tag, empty); end
        total++; if (full !== (m_q.size() == DEPTH)) begin bad++; $display("FAIL %s full got=%b", tag, full); end
        total++; if (ovf !== m_ovf) begin bad++; $display("FAIL %s ovf got=%b want=%b", tag, ovf, m_ovf); end
        total++; if (udf !== m_udf) begin bad++; $display("FAIL %s udf got=%b want=%b", tag, udf, m_udf); end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] d);
        int          n, we0, re0, exp_we, exp_re;
        logic [15:0] exp_dat, exp_addr;
        for (int i = 0; i < 8 && cmd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_timeout got=%b want=1", cmd_ready); end
        n = m_q.size(); we0 = we_cnt; re0 = re_cnt; exp_we = 0; exp_re = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 16'($urandom);
        case (op)
            2'b00: begin
                if (n == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_addr = BASE - 16'(n);
                    total++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== d) begin
                        bad++; $display("FAIL push_write we=%b addr=%h data=%h want addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_addr, d);
                    end
                    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL push_busy ready=%b want=0", cmd_ready); end
                    @(posedge clk); #1;
                    m_q.push_back(d);
                    exp_we = 1;
                end
            end
            2'b01, 2'b10: begin
                if (n == 0) begin
                    m_udf = 1'b1;
                    total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0) begin
                        bad++; $display("FAIL udf_rsp valid=%b data=%h want 1/0000", rsp_valid, rsp_data);
                    end
                    @(posedge clk); #1;
                end else begin
                    exp_dat  = m_q[n-1];
                    exp_addr = BASE - 16'(n) + 16'd1;
                    total++; if (mem_re !== 1'b1 || mem_addr !== exp_addr) begin
                        bad++; $display("FAIL read_addr re=%b addr=%h want addr=%h", mem_re, mem_addr, exp_addr);
                    end
                    @(posedge clk); #1;
                    total++; if (rsp_valid !== 1'b1 || rsp_data !== exp_dat) begin
                        bad++; $display("FAIL rsp valid=%b data=%h want data=%h", rsp_valid, rsp_data, exp_dat);
                    end
                    @(posedge clk); #1;
                    total++; if (rsp_valid !== 1'b0 || rsp_data !== exp_dat) begin
                        bad++; $display("FAIL rsp_hold valid=%b data=%h want 0/%h", rsp_valid, rsp_data, exp_dat);
                    end
                    if (op == 2'b01) void'(m_q.pop_back());
                    exp_re = 1;
                end
            end
            default: model_reset();
        endcase
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL op_done_ready op=%0d ready=%b", op, cmd_ready); end
        total++; if (we_cnt - we0 !== exp_we || re_cnt - re0 !== exp_re) begin
            bad++; $display("FAIL mem_access op=%0d writes=%0d reads=%0d want %0d/%0d", op, we_cnt - we0, re_cnt - re0, exp_we, exp_re);
        end
        check_visible("after_op");
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'h5555;
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            bad++; $display("FAIL rst_strobes ready=%b we=%b re=%b want 0", cmd_ready, mem_we, mem_re);
        end
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            bad++; $display("FAIL rst_outputs valid=%b data=%h addr=%h wdata=%h want zeros", rsp_valid, rsp_data, mem_addr, mem_wdata);
        end
        check_visible("reset");
    endtask

    task automatic test_single();
        run_op(2'b00, 16'hBEEF);
        run_op(2'b01, 16'h0000);
    endtask

    task automatic test_lifo_peek();
        run_op(2'b00, 16'd1);
        run_op(2'b00, 16'd2);
        run_op(2'b00, 16'd3);
        run_op(2'b10, 16'd0);
        for (int i = 0; i < 3; i++) run_op(2'b01, 16'd0);
        total++; if (sp !== BASE) begin bad++; $display("FAIL lifo_sp got=%h want=%h", sp, BASE); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) run_op(2'b00, 16'hA000 + 16'(i));
        total++; if (ovf !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL ovf_set ovf=%b count=%0d want 1/4", ovf, count); end
        run_op(2'b00, 16'hFFFF);
        run_op(2'b11, 16'h0);
        total++; if (ovf !== 1'b0 || sp !== BASE) begin bad++; $display("FAIL ovf_clear ovf=%b sp=%h", ovf, sp); end
    endtask

    task automatic test_underflow();
        run_op(2'b01, 16'h0);
        run_op(2'b01, 16'h0);
        run_op(2'b10, 16'h0);
        total++; if (udf !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL udf_sticky udf=%b count=%0d want 1/0", udf, count); end
        run_op(2'b11, 16'h0);
    endtask

    task automatic test_reset_mid_op();
        int we0;
        run_op(2'b00, 16'h0F0F);
        we0 = we_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'h1234;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b want=0", mem_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (we_cnt !== we0) begin bad++; $display("FAIL mid_rst_write writes=%0d want=%0d", we_cnt, we0); end
        check_visible("mid_rst");
        run_op(2'b01, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        int         r;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       op = 2'b00;
            else if (r < 14) op = 2'b01;
            else if (r < 18) op = 2'b10;
            else             op = 2'b11;
            run_op(op, 16'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0;
        model_reset();
        test_reset();
        test_single();
        test_lifo_peek();
        test_overflow();
        test_underflow();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_port_unit.md
Name: stack_port_unit

Overview:
- Responder side of the stack command interface: the control FSM issues push/pop/peek/clear requests, and this block carries them out.
- Owns the stack depth counter and stack pointer, and sequences the single-port data-memory accesses for each request.
- Flags overflow and underflow.
- Sits between the control FSM and one data-memory port; two instances serve the main stack and the return stack.

Parameters:
- DATA_W, 16, stack word width.
- ADDR_W, 16, memory word-address width.
- BASE, 16'h27FF, address of the first (bottom) stack slot; the stack grows downward.
- DEPTH, 256, maximum number of entries; must be ≤ BASE+1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  block accepts a request this cycle.
- cmd_op  input  2  00 push, 01 pop, 10 peek, 11 clear.
- cmd_data  input  DATA_W  push operand.
- rsp_valid  output  1  one-cycle pulse, pop/peek result valid.
- rsp_data  output  DATA_W  pop/peek result.
- sp  output  ADDR_W  address of the next free slot, equal to BASE − count.
- count  output  9  current entry count, 0..DEPTH (width clog2(DEPTH)+1).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe.
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_re.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, count=0, ovf=udf=0, rsp_valid=0, rsp_data=0.
  - mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
  - sp=BASE, empty=1, full=0.
  - While rst is high, cmd_ready=0.
  - Reset mid-operation abandons the request: no write completes and no response is issued.
- Handshake:
  - A request is accepted when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = (state==IDLE) && !rst.
  - cmd_op and cmd_data are registered on acceptance; the requester may change them afterwards.
- States: IDLE, WRITE, READ, RESP.
- IDLE, on acceptance:
  - push, !full → WRITE, latching cmd_data.
  - push, full → remain IDLE; set ovf; no memory access; count unchanged.
  - pop/peek, !empty → READ.
  - pop/peek, empty → RESP with underflow marked; set udf.
  - clear → remain IDLE; count=0, ovf=udf=0; no memory access; completes in one cycle.
- WRITE (one cycle):
  - mem_we=1, mem_addr=BASE−count, mem_wdata=latched data.
  - At the edge, count=count+1 → IDLE.
  - Push latency: 2 cycles from acceptance to next cmd_ready.
- READ (one cycle):
  - mem_re=1, mem_addr=BASE−count+1 (top element) → RESP.
- RESP (one cycle):
  - rsp_valid=1.
  - rsp_data=mem_rdata, or 0 if underflow.
  - Pop without underflow: count=count−1 at the exit edge.
  - Peek: count unchanged.
  - → IDLE.
  - Pop/peek latency: rsp_valid in the 2nd cycle after acceptance; cmd_ready returns in the 3rd.
- Outputs in non-access states: mem_we/mem_re are 0 outside WRITE/READ; rsp_valid is 0 outside RESP.
- rsp_data holds its last value until the next RESP.
- Arithmetic: address math is modulo 2^ADDR_W; count never wraps (guarded by full/empty).
- Flags:
  - ovf and udf stay set until clear or rst.
  - A further erroneous request leaves them set.
- Simultaneous events:
  - clear with rst → reset wins.
  - Requests presented while cmd_ready=0 are ignored and not queued.

Test Plan:
- Reset then idle: rst high 2 cycles → sp=16'h27FF, count=0, empty=1, cmd_ready=0 during rst and 1 the cycle after.
- Push then pop, single value: push 16'hBEEF → one mem_we at addr 16'h27FF, count=1, sp=16'h27FE; pop → mem_re at 16'h27FF, rsp_valid=1 with rsp_data=16'hBEEF two cycles after acceptance, count=0.
- LIFO order with peek: push 1,2,3 → peek returns 3 with count=3 kept; pops return 3,2,1; final sp=16'h27FF.
- Overflow at DEPTH=4 (override): push 5 values → 5th push makes no write, ovf=1, count=4; clear → count=0, ovf=0, sp=16'h27FF.
- Underflow: pop on empty → no mem_re, rsp_valid with rsp_data=0, udf=1, count stays 0; a second pop keeps udf=1.
- Reset mid-operation: accept push 16'h1234, assert rst in the WRITE cycle → no write commits, count=0; then pop → udf=1.
